// File: rtl/result_writer_pkg.sv
// result_writer_pkg: shared constants and FSM encoding for the result writer.
// Contents: DATA_W_DEFAULT, DEPTH_LOG2, DEPTH, LAST_INDEX, state_t (one-hot).
package result_writer_pkg;
   localparam int          DATA_W_DEFAULT = 16;
   localparam int          DEPTH_LOG2     = 6;
   localparam int          DEPTH          = 1 << DEPTH_LOG2;
   localparam logic [5:0]  LAST_INDEX     = 6'd63;
   typedef enum logic [3:0] {
      S_IDLE       = 4'b0001,
      S_COLLECT    = 4'b0010,
      S_DRAIN_REQ  = 4'b0100,
      S_DRAIN_HOLD = 4'b1000
   } state_t;
endpackage

// File: rtl/result_writer_ram.sv
// result_ram: 64 x DATA_W buffer, one synchronous write port, one synchronous read port.
// Ports: i_clk, i_rst_n (clears only the read register), i_wr_en/i_wr_addr/i_wr_data,
//        i_rd_en/i_rd_addr, o_rd_data (valid one cycle after i_rd_en, held otherwise).
module result_ram
   import result_writer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [DEPTH_LOG2-1:0] i_wr_addr,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_rd_en,
   input  logic [DEPTH_LOG2-1:0] i_rd_addr,
   output logic [DATA_W-1:0]     o_rd_data
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   always_ff @(posedge i_clk)
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)     r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/result_writer.sv
// result_writer: collects 64 MAC results of an 8x8 block and streams them out with valid/ready.
// Ports: i_clk, i_rst_n (async active-low), i_start (arm new block), i_ready (result strobe level),
//        i_mac_result, o_out_data/o_out_index/o_out_valid with i_out_ready handshake,
//        o_block_done (pulse after 64th word accepted), o_busy, o_overflow (sticky lost strobe).
module result_writer
   import result_writer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_ready,
   input  logic [DATA_W-1:0]     i_mac_result,
   output logic [DATA_W-1:0]     o_out_data,
   output logic [DEPTH_LOG2-1:0] o_out_index,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_block_done,
   output logic                  o_busy,
   output logic                  o_overflow
);
   state_t                r_state, w_state_nxt;
   logic                  r_ready_d, r_out_valid, r_block_done, r_overflow;
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic                  w_strobe, w_wr_en, w_rd_en, w_accept, w_arm;
   assign w_strobe = i_ready & ~r_ready_d;
   assign w_accept = (r_state == S_DRAIN_HOLD) && i_out_ready;
   assign w_arm    = (r_state == S_IDLE) && i_start;
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      case (r_state)
         S_IDLE:       if (i_start) w_state_nxt = S_COLLECT;
         S_COLLECT: begin
            w_wr_en = w_strobe;
            if (w_strobe && r_wr_ptr == LAST_INDEX) w_state_nxt = S_DRAIN_REQ;
         end
         S_DRAIN_REQ: begin
            w_rd_en     = 1'b1;
            w_state_nxt = S_DRAIN_HOLD;
         end
         S_DRAIN_HOLD: if (i_out_ready) w_state_nxt = (r_rd_ptr == LAST_INDEX) ? S_IDLE : S_DRAIN_REQ;
         default:      w_state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_ready_d    <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_out_valid  <= 1'b0;
         r_block_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_ready_d    <= i_ready;
         r_block_done <= w_accept && r_rd_ptr == LAST_INDEX;
         // A strobe coinciding with start is still lost, so it re-sets overflow after the clear.
         if (w_arm)                              r_overflow <= w_strobe;
         else if (w_strobe && !w_wr_en)          r_overflow <= 1'b1;
         if (w_arm)                              r_wr_ptr   <= '0;
         else if (w_wr_en)                       r_wr_ptr   <= r_wr_ptr + 6'd1;
         if (w_accept)                           r_rd_ptr   <= r_rd_ptr + 6'd1;
         if (w_rd_en)                            r_out_valid <= 1'b1;
         else if (w_accept)                      r_out_valid <= 1'b0;
      end
   result_ram #(.DATA_W(DATA_W)) u_ram (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_mac_result),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (o_out_data)
   );
   assign o_out_index  = r_rd_ptr;
   assign o_out_valid  = r_out_valid;
   assign o_block_done = r_block_done;
   assign o_busy       = r_state != S_IDLE;
   assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: directed scoreboard bench for result_writer.
module tb_result_writer;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_ready = 1'b0;
   logic [15:0] i_mac_result = '0;
   logic [15:0] o_out_data;
   logic [5:0]  o_out_index;
   logic        o_out_valid;
   logic        i_out_ready = 1'b1;
   logic        o_block_done;
   logic        o_busy;
   logic        o_overflow;
   typedef struct packed {
      logic [5:0]  idx;
      logic [15:0] data;
   } item_t;
   item_t       q[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic [5:0]  exp_idx = '0;
   result_writer #(.DATA_W(16)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_ready      (i_ready),
      .i_mac_result (i_mac_result),
      .o_out_data   (o_out_data),
      .o_out_index  (o_out_index),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_block_done (o_block_done),
      .o_busy       (o_busy),
      .o_overflow   (o_overflow)
   );
   always #5 i_clk = ~i_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(negedge i_clk) begin
      if (i_rst_n && o_out_valid && i_out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_extra_word observed index=%0d expected no word", o_out_index);
         end else begin
            item_t e;
            e = q.pop_front();
            chk("sb_index", {26'd0, o_out_index}, {26'd0, e.idx});
            chk("sb_data", {16'd0, o_out_data}, {16'd0, e.data});
         end
      end
      if (i_rst_n && o_block_done) done_cnt++;
   end
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask
   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      exp_idx = '0;
   endtask
   task automatic pulse(input logic [15:0] d, input bit push);
      i_mac_result = d;
      i_ready = 1'b1;
      if (push) begin
         q.push_back({exp_idx, d});
         exp_idx++;
      end
      tick();
      i_ready = 1'b0;
      tick();
   endtask
   task automatic wait_done(input string tag);
      int n = 0;
      int base = done_cnt;
      while (done_cnt == base && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, done_cnt - base, 1);
      repeat (3) tick();
      chk({tag, "_once"}, done_cnt - base, 1);
      chk({tag, "_empty"}, q.size(), 0);
      chk({tag, "_idle"}, {31'd0, o_busy}, 0);
   endtask
   initial begin
      int n;
      logic [15:0] held;
      repeat (3) tick();
      chk("rst_busy", {31'd0, o_busy}, 0);
      chk("rst_valid", {31'd0, o_out_valid}, 0);
      chk("rst_data", {16'd0, o_out_data}, 0);
      chk("rst_index", {26'd0, o_out_index}, 0);
      chk("rst_done", {31'd0, o_block_done}, 0);
      chk("rst_ovf", {31'd0, o_overflow}, 0);
      i_rst_n = 1'b1;
      tick();
      do_start();
      chk("t1_busy", {31'd0, o_busy}, 1);
      for (int i = 0; i < 64; i++) pulse(16'(i * 3), 1'b1);
      wait_done("t1");
      chk("t1_ovf", {31'd0, o_overflow}, 0);
      do_start();
      i_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         i_mac_result = 16'hAAAA + 16'(k);
         tick();
      end
      i_ready = 1'b0;
      tick();
      q.push_back({6'd0, 16'hAAAA});
      exp_idx = 6'd1;
      for (int i = 1; i < 64; i++) pulse(16'(i + 100), 1'b1);
      chk("t2_ovf", {31'd0, o_overflow}, 0);
      n = 0;
      while (!(o_out_valid && o_out_index == 6'd17) && n < 200) begin
         tick();
         n++;
      end
      chk("t3_reach17", {26'd0, o_out_index}, 17);
      i_out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_hold_index", {26'd0, o_out_index}, 17);
         chk("t3_hold_data", {16'd0, o_out_data}, 117);
         chk("t3_hold_valid", {31'd0, o_out_valid}, 1);
      end
      i_out_ready = 1'b1;
      wait_done("t3");
      do_start();
      for (int i = 0; i < 64; i++) pulse(16'(i * 7 + 1), 1'b1);
      i_out_ready = 1'b0;
      n = 0;
      while (!o_out_valid && n < 20) begin
         tick();
         n++;
      end
      held = o_out_data;
      chk("t4_first", {16'd0, held}, 1);
      pulse(16'hFFFF, 1'b0);
      chk("t4_ovf", {31'd0, o_overflow}, 1);
      chk("t4_data_kept", {16'd0, o_out_data}, 1);
      chk("t4_index_kept", {26'd0, o_out_index}, 0);
      i_out_ready = 1'b1;
      wait_done("t4");
      chk("t4_ovf_sticky", {31'd0, o_overflow}, 1);
      do_start();
      chk("t4_ovf_clear", {31'd0, o_overflow}, 0);
      for (int i = 0; i < 30; i++) pulse(16'(i + 500), 1'b0);
      chk("t5_busy_pre", {31'd0, o_busy}, 1);
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t5_busy", {31'd0, o_busy}, 0);
      chk("t5_data", {16'd0, o_out_data}, 0);
      chk("t5_index", {26'd0, o_out_index}, 0);
      chk("t5_valid", {31'd0, o_out_valid}, 0);
      chk("t5_done", {31'd0, o_block_done}, 0);
      n = done_cnt;
      repeat (2) tick();
      i_rst_n = 1'b1;
      repeat (3) tick();
      chk("t5_no_done", done_cnt - n, 0);
      chk("t5_idle", {31'd0, o_busy}, 0);
      do_start();
      for (int i = 0; i < 64; i++) pulse(16'h1000 + 16'(i), 1'b1);
      wait_done("t5");
      i_mac_result = 16'hDEAD;
      i_start = 1'b1;
      i_ready = 1'b1;
      tick();
      i_start = 1'b0;
      i_ready = 1'b0;
      tick();
      chk("t6_busy", {31'd0, o_busy}, 1);
      chk("t6_ovf", {31'd0, o_overflow}, 1);
      exp_idx = '0;
      for (int i = 0; i < 64; i++) pulse(16'h2000 + 16'(i), 1'b1);
      wait_done("t6");
      chk("t6_ovf_sticky", {31'd0, o_overflow}, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter DATA_W, default 16, width of one MAC result word.
REQ-002 Parameter DEPTH_LOG2, fixed at 6; 64 results per 8x8 block, index {x,y}.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-005 start  in  1  same start pulse the address-generating controller receives; arms collection of a new block.
REQ-006 ready  in  1  controller result strobe; each rising edge marks one finished accumulation.
REQ-007 mac_result  in  DATA_W  accumulator value; valid in the cycle the ready rising edge is detected.
REQ-008 out_data  out  DATA_W  streamed result word.
REQ-009 out_index  out  6  {x,y} index of out_data.
REQ-010 out_valid  out  1  out_data/out_index valid.
REQ-011 out_ready  in  1  downstream accepts the word when out_valid&&out_ready.
REQ-012 block_done  out  1  one-cycle pulse when the 64th word has been accepted downstream.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 overflow  out  1  sticky; set when a result strobe arrives while it cannot be stored.

Function
REQ-015 Strobe detect: register ready into ready_d; strobe = ready && !ready_d; a level held high counts once.
REQ-016 FSM states: IDLE, COLLECT, DRAIN_REQ, DRAIN_HOLD.
REQ-017 IDLE -> COLLECT on start; wr_ptr cleared to 0 and overflow cleared in that transition.
REQ-018 COLLECT: on strobe, write mac_result to buffer[wr_ptr] in that cycle and increment wr_ptr; wr_ptr order equals controller order (y inner, x outer).
REQ-019 COLLECT -> DRAIN_REQ in the cycle after the write at wr_ptr=63; wr_ptr wraps to 0.
REQ-020 DRAIN_REQ: issue buffer read at rd_ptr; 1-cycle read latency; next state DRAIN_HOLD with out_valid=1.
REQ-021 DRAIN_HOLD: out_data, out_index=rd_ptr and out_valid stay stable until out_ready; no word is dropped or duplicated.
REQ-022 On acceptance with rd_ptr<63: increment rd_ptr, out_valid=0, go to DRAIN_REQ (max throughput one word per 2 cycles).
REQ-023 On acceptance with rd_ptr=63: pulse block_done, rd_ptr wraps to 0, go to IDLE.
REQ-024 Strobe in IDLE, DRAIN_REQ or DRAIN_HOLD: word discarded, overflow set, state unaffected.
REQ-025 start while busy is ignored.
REQ-026 start and strobe in the same IDLE cycle: transition to COLLECT; the strobe is discarded and sets overflow after the clear.
REQ-027 Buffer content is not cleared; only written locations are ever read.

Reset
REQ-028 reset low: state=IDLE, wr_ptr=0, rd_ptr=0, ready_d=0, out_valid=0, out_data=0, out_index=0, block_done=0, busy=0, overflow=0.
REQ-029 reset mid-block aborts collection or drain with no block_done; the next block requires a new start.

Structure
REQ-030 Shared package holds: DATA_W default, DEPTH_LOG2, LAST_INDEX=63, and the FSM state encoding (one-hot, 4 bits).
REQ-031 One sub-module, result_ram: 64xDATA_W, one synchronous write port, one synchronous read port, no reset on the array.

Verification
REQ-032 start, then 64 ready pulses with mac_result=index*3, out_ready=1 -> out_index 0..63 in order, out_data=index*3, block_done pulses exactly once after index 63.
REQ-033 ready held high 5 cycles during COLLECT -> exactly one word written; wr_ptr advances by 1.
REQ-034 out_ready low for 10 cycles at index 17 -> out_data/out_index held stable at 17, then 18 follows with no gap error.
REQ-035 ready pulse during DRAIN_HOLD -> overflow=1, drained data unchanged; next start clears overflow.
REQ-036 reset asserted after 30 strobes -> all outputs 0 immediately; new start + 64 strobes yields a clean block.
REQ-037 start together with a strobe in IDLE -> COLLECT entered, overflow=1, first stored word is the next strobe at index 0.
